cle34_seq_tx: RTL and testbench

- Initiator-side sequencer for the CLE34 address-coded serial link.
- Takes a parallel word and replays it as a framed series of bus write cycles. Each cycle is qualified by SSER low, BA13 low, BA12 high and BR_W high, and carries a symbol on BA7..BA4.
- Samples the responder's SDRD readback during the trailing read phase and reports whether the responder acknowledged.
- Sits between the host control register block and the backplane bus drivers.

---
 rtl/cle34_pkg.sv | 38 +++
 rtl/cle34_sym_timer.sv | 91 +++++++++
 rtl/cle34_seq_tx.sv | 157 +++++++++++++++
 tb/tb_cle34_seq_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cle34_pkg.sv
// Shared constants and types for the CLE34 initiator-side sequencer.
// Symbol codes, qualifier idle levels, FSM and symbol-phase enums.
package cle34_pkg;

  localparam logic [3:0] SYM_SYNC = 4'b0010;
  localparam logic [3:0] SYM_D0   = 4'b1000;
  localparam logic [3:0] SYM_D1   = 4'b1010;
  localparam logic [3:0] SYM_END  = 4'b1001;
  localparam logic [3:0] SYM_RDQ  = 4'b0101;

  // Qualifier levels while no symbol is on the bus; a symbol drives the inverse.
  localparam logic SSER_N_IDLE = 1'b1;
  localparam logic BA13_IDLE   = 1'b1;
  localparam logic BA12_IDLE   = 1'b0;
  localparam logic BR_W_IDLE   = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PAR,
    END,
    RDQ
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_GAP,
    PH_SETUP,
    PH_STB,
    PH_HOLD
  } phase_t;

  function automatic logic [3:0] bit_sym(input logic b);
    return b ? SYM_D1 : SYM_D0;
  endfunction

endpackage

// File: rtl/cle34_sym_timer.sv
// Per-symbol bus timing: GAP idle clocks, 1 setup clock, STB_HI strobe clocks,
// 1 hold clock. sym_done marks the hold clock so the next symbol can follow.
module cle34_sym_timer
  import cle34_pkg::*;
#(
  parameter int STB_HI = 2,
  parameter int GAP    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] sym,
  output logic       sym_done,
  output logic       stb_fall,
  output logic       bus_sser_n,
  output logic       bus_ba13,
  output logic       bus_ba12,
  output logic [3:0] bus_ba,
  output logic       bus_br_w,
  output logic       bus_stb
);

  localparam int MAXC = (GAP > STB_HI) ? GAP : STB_HI;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  phase_t        phase;
  logic [CW-1:0] cnt;

  assign sym_done = (phase == PH_HOLD);
  assign stb_fall = (phase == PH_STB) && (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= PH_IDLE;
      cnt        <= '0;
      bus_sser_n <= SSER_N_IDLE;
      bus_ba13   <= BA13_IDLE;
      bus_ba12   <= BA12_IDLE;
      bus_ba     <= 4'b0000;
      bus_br_w   <= BR_W_IDLE;
      bus_stb    <= 1'b0;
    end else begin
      case (phase)
        PH_IDLE, PH_HOLD: begin
          bus_sser_n <= SSER_N_IDLE;
          bus_ba13   <= BA13_IDLE;
          bus_ba12   <= BA12_IDLE;
          bus_ba     <= 4'b0000;
          bus_br_w   <= BR_W_IDLE;
          bus_stb    <= 1'b0;
          if (start) begin
            phase <= PH_GAP;
            cnt   <= CW'(GAP - 1);
          end else begin
            phase <= PH_IDLE;
          end
        end
        PH_GAP: begin
          if (cnt == '0) begin
            // Symbol code is taken here, after the FSM has settled on it.
            phase      <= PH_SETUP;
            bus_sser_n <= ~SSER_N_IDLE;
            bus_ba13   <= ~BA13_IDLE;
            bus_ba12   <= ~BA12_IDLE;
            bus_br_w   <= ~BR_W_IDLE;
            bus_ba     <= sym;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PH_SETUP: begin
          phase   <= PH_STB;
          bus_stb <= 1'b1;
          cnt     <= CW'(STB_HI - 1);
        end
        PH_STB: begin
          if (cnt == '0) begin
            phase   <= PH_HOLD;
            bus_stb <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cle34_seq_tx.sv
// CLE34 initiator sequencer: frames a parallel word as SYNC, data, END, RDQ
// symbols and reports the responder's SDRD acknowledge. Option: CLE34_TX_PARITY_EN.
module cle34_seq_tx
  import cle34_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STB_HI = 2,
  parameter int GAP    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              busy,
  output logic              bus_sser_n,
  output logic              bus_ba13,
  output logic              bus_ba12,
  output logic [3:0]        bus_ba,
  output logic              bus_br_w,
  output logic              bus_stb,
  input  logic              sdrd_in,
  output logic              done,
  output logic              ack_ok
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sdrd_s1, sdrd_s2, rd_sample;
  logic              start, sym_done, stb_fall, accept;
  logic [3:0]        sym;
`ifdef CLE34_TX_PARITY_EN
  logic              par_bit;
`endif

  assign accept   = tx_valid && tx_ready;
  assign tx_ready = (state == IDLE) && !done;
  assign busy     = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    sym     = SYM_SYNC;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SYNC;
          start   = 1'b1;
        end
      end
      SYNC: begin
        if (sym_done) begin
          state_n = DATA;
          start   = 1'b1;
        end
      end
      DATA: begin
        sym = bit_sym(sreg[DATA_W-1]);
        if (sym_done) begin
          start = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef CLE34_TX_PARITY_EN
            state_n = PAR;
`else
            state_n = END;
`endif
          end
        end
      end
`ifdef CLE34_TX_PARITY_EN
      PAR: begin
        sym = bit_sym(par_bit);
        if (sym_done) begin
          state_n = END;
          start   = 1'b1;
        end
      end
`endif
      END: begin
        sym = SYM_END;
        if (sym_done) begin
          state_n = RDQ;
          start   = 1'b1;
        end
      end
      RDQ: begin
        sym = SYM_RDQ;
        if (sym_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      sdrd_s1   <= 1'b1;
      sdrd_s2   <= 1'b1;
      rd_sample <= 1'b1;
      done      <= 1'b0;
      ack_ok    <= 1'b0;
`ifdef CLE34_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sdrd_s1 <= sdrd_in;
      sdrd_s2 <= sdrd_s1;
      done    <= 1'b0;
      ack_ok  <= 1'b0;
      if (accept) begin
        sreg    <= tx_data;
        bit_cnt <= '0;
`ifdef CLE34_TX_PARITY_EN
        par_bit <= ^tx_data;
`endif
      end
      if (state == DATA && sym_done) begin
        sreg    <= sreg << 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      // The responder drives SDRD while it sees the RDQ strobe; take it as the strobe drops.
      if (state == RDQ && stb_fall) rd_sample <= sdrd_s2;
      if (state == RDQ && sym_done) begin
        done   <= 1'b1;
        ack_ok <= ~rd_sample;
      end
    end
  end

  cle34_sym_timer #(
    .STB_HI(STB_HI),
    .GAP   (GAP)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sym       (sym),
    .sym_done  (sym_done),
    .stb_fall  (stb_fall),
    .bus_sser_n(bus_sser_n),
    .bus_ba13  (bus_ba13),
    .bus_ba12  (bus_ba12),
    .bus_ba    (bus_ba),
    .bus_br_w  (bus_br_w),
    .bus_stb   (bus_stb)
  );

endmodule

// File: tb/tb_cle34_seq_tx.sv
// Directed bench for cle34_seq_tx (DATA_W=8, STB_HI=2, GAP=3): frame table
// plus hand sequences for back-to-back offers and mid-frame reset.
module tb_cle34_seq_tx;

  localparam logic [3:0] C_SYNC = 4'b0010;
  localparam logic [3:0] C_D0   = 4'b1000;
  localparam logic [3:0] C_D1   = 4'b1010;
  localparam logic [3:0] C_END  = 4'b1001;
  localparam logic [3:0] C_RDQ  = 4'b0101;
`ifdef CLE34_TX_PARITY_EN
  localparam int EXP_LEN = 84;
`else
  localparam int EXP_LEN = 77;
`endif

  typedef struct {
    logic [7:0] data;
    logic       sdrd;
    logic       exp_ack;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sdrd_in = 1'b1;
  logic       tx_ready, busy, bus_sser_n, bus_ba13, bus_ba12, bus_br_w, bus_stb;
  logic [3:0] bus_ba;
  logic       done, ack_ok;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cle34_seq_tx #(.DATA_W(8), .STB_HI(2), .GAP(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .bus_sser_n(bus_sser_n),
    .bus_ba13  (bus_ba13),
    .bus_ba12  (bus_ba12),
    .bus_ba    (bus_ba),
    .bus_br_w  (bus_br_w),
    .bus_stb   (bus_stb),
    .sdrd_in   (sdrd_in),
    .done      (done),
    .ack_ok    (ack_ok)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sser_n"}, 32'(bus_sser_n), 32'd1);
    check({tag, "_ba13"}, 32'(bus_ba13), 32'd1);
    check({tag, "_ba12"}, 32'(bus_ba12), 32'd0);
    check({tag, "_ba"}, 32'(bus_ba), 32'd0);
    check({tag, "_br_w"}, 32'(bus_br_w), 32'd0);
    check({tag, "_stb"}, 32'(bus_stb), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Offers one frame and follows it to done. With hold_valid, tx_valid stays
  // high and tx_data switches to new_data mid-frame.
  task automatic run_frame(input logic [7:0] data, input logic sdrd, input logic exp_ack,
                           input bit hold_valid, input logic [7:0] new_data);
    logic [3:0] exp_sym [0:15];
    logic [3:0] got [0:15];
    int   ne, nsym, n;
    bit   seen, qual_bad;
    logic prev_stb;
    exp_sym[0] = C_SYNC;
    for (int i = 0; i < 8; i++) exp_sym[1 + i] = data[7 - i] ? C_D1 : C_D0;
    ne = 9;
`ifdef CLE34_TX_PARITY_EN
    exp_sym[9] = (^data) ? C_D1 : C_D0;
    ne = 10;
`endif
    exp_sym[ne] = C_END;
    exp_sym[ne + 1] = C_RDQ;
    ne = ne + 2;

    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    sdrd_in  = sdrd;
    check("ready_before_accept", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_after_accept", 32'(tx_ready), 32'd0);
    if (!hold_valid) tx_valid = 1'b0;

    n = 0; nsym = 0; seen = 0; qual_bad = 0; prev_stb = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (hold_valid && n == 20) tx_data = new_data;
      if (bus_stb && !prev_stb) begin
        if (nsym < 16) got[nsym] = bus_ba;
        nsym++;
        if (bus_sser_n !== 1'b0 || bus_ba13 !== 1'b0 || bus_ba12 !== 1'b1 || bus_br_w !== 1'b1)
          qual_bad = 1;
      end
      prev_stb = bus_stb;
      if (done) seen = 1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("frame_len", 32'(n), 32'(EXP_LEN));
    check("sym_count", 32'(nsym), 32'(ne));
    for (int i = 0; i < ne && i < nsym && i < 16; i++)
      check($sformatf("sym%0d_of_%02h", i, data), 32'(got[i]), 32'(exp_sym[i]));
    check("qualifiers_during_stb", 32'(qual_bad), 32'd0);
    check("ack_ok", 32'(ack_ok), 32'(exp_ack));
    check("ready_low_with_done", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("done_single_pulse", 32'(done), 32'd0);
    check("ready_after_done", 32'(tx_ready), 32'd1);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vecs [0:4];
    int   dcnt;
    vecs[0] = '{data: 8'hA5, sdrd: 1'b0, exp_ack: 1'b1};
    vecs[1] = '{data: 8'h00, sdrd: 1'b1, exp_ack: 1'b0};
    vecs[2] = '{data: 8'hFF, sdrd: 1'b0, exp_ack: 1'b1};
    vecs[3] = '{data: 8'h07, sdrd: 1'b1, exp_ack: 1'b0};
    vecs[4] = '{data: 8'h5A, sdrd: 1'b0, exp_ack: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_idle("in_reset");
    check("ack_in_reset", 32'(ack_ok), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle("after_reset");

    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].data, vecs[v].sdrd, vecs[v].exp_ack, 1'b0, 8'h00);

    // Offer held high across a frame with changing data: the second frame
    // must wait for tx_ready and the first must keep its captured bits.
    run_frame(8'h3C, 1'b0, 1'b1, 1'b1, 8'hC3);
    run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);

    // One-clock reset during the strobe of the 4th data symbol (bit 4 of A5 is 0).
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    sdrd_in  = 1'b0;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("mid_stb_high", 32'(bus_stb), 32'd1);
    check("mid_sym_d0", 32'(bus_ba), 32'(C_D0));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_idle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("no_done_after_abort", 32'(dcnt), 32'd0);
    check_idle("post_abort");

    run_frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
